// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of one single-port SRAM: round-robin with per-requester lock,
// one-cycle response routing to the granted side, and a saturating dual-request counter.
module sram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 15,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      m0_req_i,
    input  logic                      m0_lock_i,
    input  logic                      m0_we_i,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    output logic                      m0_gnt_o,
    output logic                      m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,

    input  logic                      m1_req_i,
    input  logic                      m1_lock_i,
    input  logic                      m1_we_i,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic                      m1_gnt_o,
    output logic                      m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,

    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

    output logic [CNT_WIDTH-1:0]      conflict_cnt_o,
    input  logic                      clr_cnt_i
);

    logic                  r_rr_ptr;    // 0: m0 wins a tie, 1: m1 wins a tie
    logic                  r_lock_vld;
    logic                  r_lock_own;
    logic                  r_rsp_vld;
    logic                  r_rsp_own;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_both;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any;
    logic                  w_gnt_lock;
    logic                  w_own_lock;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_unused_addr;

    assign w_both = m0_req_i & m1_req_i;

    // A held lock blocks the other side even while the owner is idle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_lock_vld) begin
            if (r_lock_own) begin
                w_gnt1 = m1_req_i;
            end else begin
                w_gnt0 = m0_req_i;
            end
        end else if (w_both) begin
            if (r_rr_ptr) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b1;
            end
        end else begin
            w_gnt0 = m0_req_i;
            w_gnt1 = m1_req_i;
        end
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_any      = w_gnt0 | w_gnt1;
    assign w_gnt_lock = w_gnt1 ? m1_lock_i : m0_lock_i;
    assign w_own_lock = r_lock_own ? m1_lock_i : m0_lock_i;
    assign w_addr     = w_gnt1 ? m1_addr_i : m0_addr_i;

    assign w_unused_addr = ^{w_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], w_addr[1:0]};

    assign m0_gnt_o    = w_gnt0;
    assign m1_gnt_o    = w_gnt1;
    assign mem_en_o    = w_any;
    assign mem_we_o    = w_any & (w_gnt1 ? m1_we_i : m0_we_i);
    assign mem_addr_o  = w_addr[MEM_ADDR_WIDTH+1:2];
    assign mem_be_o    = w_gnt1 ? m1_be_i : m0_be_i;
    assign mem_wdata_o = w_gnt1 ? m1_wdata_i : m0_wdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= 1'b0;
            r_lock_vld <= 1'b0;
            r_lock_own <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_own  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_rsp_vld <= w_any;
            if (w_any) begin
                r_rsp_own <= w_gnt1;
            end

            if (w_any && !w_gnt_lock) begin
                r_rr_ptr <= ~w_gnt1;
            end

            // While locked the owner's gnt follows its req, so its lock input alone
            // decides release: granted with lock=0 or idle with lock=0.
            if (r_lock_vld) begin
                r_lock_vld <= w_own_lock;
            end else if (w_any && w_gnt_lock) begin
                r_lock_vld <= 1'b1;
                r_lock_own <= w_gnt1;
            end

            if (clr_cnt_i) begin
                r_cnt <= '0;
            end else if (w_both && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign m0_rvalid_o    = r_rsp_vld & ~r_rsp_own;
    assign m1_rvalid_o    = r_rsp_vld & r_rsp_own;
    assign m0_rdata_o     = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o     = m1_rvalid_o ? mem_rdata_i : '0;
    assign conflict_cnt_o = r_cnt;

endmodule
